// File: rtl/control_unit_zicsr_if.sv
// Decoder bus: instruction fields and fetch exception in, registered control word out.
interface control_unit_zicsr_if;
  logic [6:0] Op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] funct5;
  logic [1:0] priv_mode;
  logic       exc_req_if2id;
  logic [3:0] exc_code_if_id;

  logic [1:0] ALUOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [5:0] Branch;
  logic       RegWrite;
  logic [1:0] MemtoReg;
  logic       MemRead;
  logic       MemWrite;
  logic       jal;
  logic       jalr;
  logic       valid;
  logic       dmem_addr_sel;
  logic [1:0] csr_ops;
  logic [2:0] sys_ops;
  logic       exc_req;
  logic [3:0] exc_code;

  modport master (
    output Op, funct3, funct7, funct5, priv_mode, exc_req_if2id, exc_code_if_id,
    input  ALUOp, ALUSrcA, ALUSrcB, Branch, RegWrite, MemtoReg, MemRead, MemWrite,
    input  jal, jalr, valid, dmem_addr_sel, csr_ops, sys_ops, exc_req, exc_code
  );

  modport slave (
    input  Op, funct3, funct7, funct5, priv_mode, exc_req_if2id, exc_code_if_id,
    output ALUOp, ALUSrcA, ALUSrcB, Branch, RegWrite, MemtoReg, MemRead, MemWrite,
    output jal, jalr, valid, dmem_addr_sel, csr_ops, sys_ops, exc_req, exc_code
  );
endinterface

// File: rtl/control_unit_zicsr.sv
// ID-stage decoder for RV32I + Zicsr + privileged ops; one registered control word per cycle.
module control_unit_zicsr (
  input logic                  clk_i,
  input logic                  rst_ni,
  control_unit_zicsr_if.slave  bus_io
);

  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpImm     = 7'b0010011;
  localparam logic [6:0] OpReg     = 7'b0110011;
  localparam logic [6:0] OpAmo     = 7'b0101111;
  localparam logic [6:0] OpMiscMem = 7'b0001111;
  localparam logic [6:0] OpSystem  = 7'b1110011;

  localparam logic [2:0] SysNone   = 3'b000;
  localparam logic [2:0] SysEcall  = 3'b001;
  localparam logic [2:0] SysEbreak = 3'b010;
  localparam logic [2:0] SysMret   = 3'b011;
  localparam logic [2:0] SysSret   = 3'b100;
  localparam logic [2:0] SysWfi    = 3'b101;
  localparam logic [2:0] SysSfence = 3'b110;

  localparam logic [3:0] ExcIllegal = 4'd2;
  localparam logic [3:0] ExcBreak   = 4'd3;
  localparam logic [3:0] ExcEcallU  = 4'd8;
  localparam logic [3:0] ExcEcallS  = 4'd9;
  localparam logic [3:0] ExcEcallM  = 4'd11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [5:0] branch;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       jal;
    logic       jalr;
    logic       valid;
    logic       dmem_addr_sel;
    logic [1:0] csr_ops;
    logic [2:0] sys_ops;
    logic       exc_req;
    logic [3:0] exc_code;
  } ctrl_t;

  ctrl_t      dec;
  ctrl_t      ctrl_d;
  ctrl_t      ctrl_q;
  logic       illegal;
  logic       trap;
  logic [3:0] trap_code;

  // Raw field decode; exceptions are folded in afterwards.
  always_comb begin
    dec       = '0;
    illegal   = 1'b0;
    trap      = 1'b0;
    trap_code = 4'd0;

    unique case (bus_io.Op)
      OpLui: begin
        dec.reg_write = 1'b1;
        dec.alu_src_a = 2'b10;
        dec.alu_src_b = 2'b01;
      end
      OpAuipc: begin
        dec.reg_write = 1'b1;
        dec.alu_src_a = 2'b01;
        dec.alu_src_b = 2'b01;
      end
      OpJal: begin
        dec.jal        = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 2'b10;
      end
      OpJalr: begin
        if (bus_io.funct3 == 3'b000) begin
          dec.jalr       = 1'b1;
          dec.reg_write  = 1'b1;
          dec.mem_to_reg = 2'b10;
          dec.alu_src_b  = 2'b01;
        end else begin
          illegal = 1'b1;
        end
      end
      OpBranch: begin
        dec.alu_op = 2'b01;
        unique case (bus_io.funct3)
          3'b000:  dec.branch = 6'b000001;
          3'b001:  dec.branch = 6'b000010;
          3'b100:  dec.branch = 6'b000100;
          3'b101:  dec.branch = 6'b001000;
          3'b110:  dec.branch = 6'b010000;
          3'b111:  dec.branch = 6'b100000;
          default: illegal = 1'b1;
        endcase
      end
      OpLoad: begin
        unique case (bus_io.funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
            dec.mem_read   = 1'b1;
            dec.reg_write  = 1'b1;
            dec.mem_to_reg = 2'b01;
            dec.alu_src_b  = 2'b01;
          end
          default: illegal = 1'b1;
        endcase
      end
      OpStore: begin
        unique case (bus_io.funct3)
          3'b000, 3'b001, 3'b010: begin
            dec.mem_write = 1'b1;
            dec.alu_src_b = 2'b01;
          end
          default: illegal = 1'b1;
        endcase
      end
      OpImm: begin
        dec.alu_op    = 2'b11;
        dec.alu_src_b = 2'b01;
        dec.reg_write = 1'b1;
      end
      OpReg: begin
        dec.alu_op    = 2'b10;
        dec.reg_write = 1'b1;
        if (bus_io.funct7 != 7'b0000000 && bus_io.funct7 != 7'b0100000) begin
          illegal = 1'b1;
        end
      end
      OpAmo: begin
        if (bus_io.funct3 == 3'b010) begin
          dec.dmem_addr_sel = 1'b1;
          dec.reg_write     = 1'b1;
          dec.mem_to_reg    = 2'b01;
          dec.mem_read      = 1'b1;
          // LR.W only reads; every other AMO (incl. SC.W) writes back.
          dec.mem_write     = (bus_io.funct5 != 5'b00010);
        end else begin
          illegal = 1'b1;
        end
      end
      OpMiscMem: ;
      OpSystem: begin
        unique case (bus_io.funct3)
          3'b000: begin
            unique case (bus_io.funct7)
              7'b0000000: begin
                if (bus_io.funct5 == 5'b00000) begin
                  dec.sys_ops = SysEcall;
                  trap        = 1'b1;
                  unique case (bus_io.priv_mode)
                    2'b11:   trap_code = ExcEcallM;
                    2'b01:   trap_code = ExcEcallS;
                    default: trap_code = ExcEcallU;
                  endcase
                end else if (bus_io.funct5 == 5'b00001) begin
                  dec.sys_ops = SysEbreak;
                  trap        = 1'b1;
                  trap_code   = ExcBreak;
                end else begin
                  illegal = 1'b1;
                end
              end
              7'b0001000: begin
                if (bus_io.funct5 == 5'b00010 && bus_io.priv_mode != 2'b00) begin
                  dec.sys_ops = SysSret;
                end else if (bus_io.funct5 == 5'b00101) begin
                  dec.sys_ops = SysWfi;
                end else begin
                  illegal = 1'b1;
                end
              end
              7'b0011000: begin
                if (bus_io.funct5 == 5'b00010 && bus_io.priv_mode == 2'b11) begin
                  dec.sys_ops = SysMret;
                end else begin
                  illegal = 1'b1;
                end
              end
              7'b0001001: begin
                if (bus_io.priv_mode != 2'b00) begin
                  dec.sys_ops = SysSfence;
                end else begin
                  illegal = 1'b1;
                end
              end
              default: illegal = 1'b1;
            endcase
          end
          3'b001, 3'b101: begin
            dec.csr_ops    = 2'b01;
            dec.reg_write  = 1'b1;
            dec.mem_to_reg = 2'b11;
          end
          3'b010, 3'b110: begin
            dec.csr_ops    = 2'b10;
            dec.reg_write  = 1'b1;
            dec.mem_to_reg = 2'b11;
          end
          3'b011, 3'b111: begin
            dec.csr_ops    = 2'b11;
            dec.reg_write  = 1'b1;
            dec.mem_to_reg = 2'b11;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  // Priority: fetch exception, then illegal instruction, then ECALL/EBREAK.
  always_comb begin
    ctrl_d = dec;
    if (bus_io.exc_req_if2id || illegal || trap) begin
      ctrl_d.reg_write = 1'b0;
      ctrl_d.mem_read  = 1'b0;
      ctrl_d.mem_write = 1'b0;
      ctrl_d.branch    = '0;
      ctrl_d.jal       = 1'b0;
      ctrl_d.jalr      = 1'b0;
      ctrl_d.csr_ops   = 2'b00;
      ctrl_d.valid     = 1'b0;
      ctrl_d.exc_req   = 1'b1;
      if (bus_io.exc_req_if2id) begin
        ctrl_d.exc_code = bus_io.exc_code_if_id;
        ctrl_d.sys_ops  = SysNone;
      end else if (illegal) begin
        ctrl_d.exc_code = ExcIllegal;
        ctrl_d.sys_ops  = SysNone;
      end else begin
        ctrl_d.exc_code = trap_code;
      end
    end else begin
      ctrl_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign bus_io.ALUOp         = ctrl_q.alu_op;
  assign bus_io.ALUSrcA       = ctrl_q.alu_src_a;
  assign bus_io.ALUSrcB       = ctrl_q.alu_src_b;
  assign bus_io.Branch        = ctrl_q.branch;
  assign bus_io.RegWrite      = ctrl_q.reg_write;
  assign bus_io.MemtoReg      = ctrl_q.mem_to_reg;
  assign bus_io.MemRead       = ctrl_q.mem_read;
  assign bus_io.MemWrite      = ctrl_q.mem_write;
  assign bus_io.jal           = ctrl_q.jal;
  assign bus_io.jalr          = ctrl_q.jalr;
  assign bus_io.valid         = ctrl_q.valid;
  assign bus_io.dmem_addr_sel = ctrl_q.dmem_addr_sel;
  assign bus_io.csr_ops       = ctrl_q.csr_ops;
  assign bus_io.sys_ops       = ctrl_q.sys_ops;
  assign bus_io.exc_req       = ctrl_q.exc_req;
  assign bus_io.exc_code      = ctrl_q.exc_code;

endmodule

// File: tb/tb_control_unit_zicsr.sv
// Directed-vector bench for control_unit_zicsr with hand-computed expectations.
module tb_control_unit_zicsr;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  control_unit_zicsr_if bus ();

  control_unit_zicsr dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one instruction between edges, then sample just after the capturing edge.
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] f5, input logic [1:0] priv);
    @(negedge clk);
    bus.Op        = op;
    bus.funct3    = f3;
    bus.funct7    = f7;
    bus.funct5    = f5;
    bus.priv_mode = priv;
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] Sys = 7'b1110011;

  logic [2:0] csr_f3  [4];
  logic [1:0] csr_exp [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    csr_f3  = '{3'b001, 3'b010, 3'b011, 3'b101};
    csr_exp = '{2'b01, 2'b10, 2'b11, 2'b01};

    rst_n              = 1'b0;
    bus.exc_req_if2id  = 1'b0;
    bus.exc_code_if_id = 4'd0;

    // Reset holds everything at zero even with a LOAD on the inputs.
    drive(7'b0000011, 3'b010, 7'd0, 5'd0, 2'b11);
    drive(7'b0000011, 3'b010, 7'd0, 5'd0, 2'b11);
    check("rst_valid", 32'(bus.valid), 0);
    check("rst_exc_req", 32'(bus.exc_req), 0);
    check("rst_memread", 32'(bus.MemRead), 0);
    check("rst_regwrite", 32'(bus.RegWrite), 0);
    check("rst_memtoreg", 32'(bus.MemtoReg), 0);
    check("rst_alusrcb", 32'(bus.ALUSrcB), 0);

    rst_n = 1'b1;
    drive(7'b0000011, 3'b010, 7'd0, 5'd0, 2'b11);
    check("load_memread", 32'(bus.MemRead), 1);
    check("load_memtoreg", 32'(bus.MemtoReg), 1);
    check("load_alusrcb", 32'(bus.ALUSrcB), 1);
    check("load_regwrite", 32'(bus.RegWrite), 1);
    check("load_valid", 32'(bus.valid), 1);

    for (int i = 0; i < 4; i++) begin
      drive(Sys, csr_f3[i], 7'd0, 5'd0, 2'b11);
      check($sformatf("csr%0d_ops", i), 32'(bus.csr_ops), 32'(csr_exp[i]));
      check($sformatf("csr%0d_regwrite", i), 32'(bus.RegWrite), 1);
      check($sformatf("csr%0d_memtoreg", i), 32'(bus.MemtoReg), 3);
      check($sformatf("csr%0d_valid", i), 32'(bus.valid), 1);
      check($sformatf("csr%0d_exc", i), 32'(bus.exc_req), 0);
    end

    drive(Sys, 3'b000, 7'd0, 5'd0, 2'b11);
    check("ecall_m_sys", 32'(bus.sys_ops), 1);
    check("ecall_m_exc", 32'(bus.exc_req), 1);
    check("ecall_m_code", 32'(bus.exc_code), 11);
    check("ecall_m_valid", 32'(bus.valid), 0);
    drive(Sys, 3'b000, 7'd0, 5'd0, 2'b01);
    check("ecall_s_code", 32'(bus.exc_code), 9);
    drive(Sys, 3'b000, 7'd0, 5'd0, 2'b00);
    check("ecall_u_code", 32'(bus.exc_code), 8);
    drive(Sys, 3'b000, 7'd0, 5'b00001, 2'b11);
    check("ebreak_sys", 32'(bus.sys_ops), 2);
    check("ebreak_code", 32'(bus.exc_code), 3);
    check("ebreak_exc", 32'(bus.exc_req), 1);

    drive(Sys, 3'b000, 7'b0001000, 5'b00010, 2'b11);
    check("sret_m_sys", 32'(bus.sys_ops), 4);
    check("sret_m_valid", 32'(bus.valid), 1);
    check("sret_m_exc", 32'(bus.exc_req), 0);
    drive(Sys, 3'b000, 7'b0001000, 5'b00010, 2'b00);
    check("sret_u_exc", 32'(bus.exc_req), 1);
    check("sret_u_code", 32'(bus.exc_code), 2);
    check("sret_u_sys", 32'(bus.sys_ops), 0);
    check("sret_u_valid", 32'(bus.valid), 0);
    drive(Sys, 3'b000, 7'b0001000, 5'b00101, 2'b00);
    check("wfi_sys", 32'(bus.sys_ops), 5);
    check("wfi_valid", 32'(bus.valid), 1);

    drive(Sys, 3'b000, 7'b0011000, 5'b00010, 2'b11);
    check("mret_m_sys", 32'(bus.sys_ops), 3);
    check("mret_m_valid", 32'(bus.valid), 1);
    drive(Sys, 3'b000, 7'b0011000, 5'b00010, 2'b01);
    check("mret_s_exc", 32'(bus.exc_req), 1);
    check("mret_s_code", 32'(bus.exc_code), 2);

    drive(Sys, 3'b000, 7'b0001001, 5'd3, 2'b01);
    check("sfence_s_sys", 32'(bus.sys_ops), 6);
    drive(Sys, 3'b000, 7'b0001001, 5'd3, 2'b00);
    check("sfence_u_exc", 32'(bus.exc_req), 1);
    drive(Sys, 3'b100, 7'd0, 5'd0, 2'b11);
    check("sys_f3_100_exc", 32'(bus.exc_req), 1);

    drive(Sys, 3'b111, 7'b1111111, 5'd0, 2'b11);
    check("csrrci_ops", 32'(bus.csr_ops), 3);
    check("csrrci_valid", 32'(bus.valid), 1);

    drive(7'b1111111, 3'b000, 7'd0, 5'd0, 2'b11);
    check("badop_exc", 32'(bus.exc_req), 1);
    check("badop_code", 32'(bus.exc_code), 2);
    check("badop_regwrite", 32'(bus.RegWrite), 0);

    bus.exc_req_if2id  = 1'b1;
    bus.exc_code_if_id = 4'b0001;
    drive(7'b0110011, 3'b000, 7'd0, 5'd0, 2'b11);
    check("ifexc_code", 32'(bus.exc_code), 1);
    check("ifexc_exc", 32'(bus.exc_req), 1);
    check("ifexc_regwrite", 32'(bus.RegWrite), 0);
    check("ifexc_valid", 32'(bus.valid), 0);
    bus.exc_req_if2id = 1'b0;
    drive(7'b0110011, 3'b000, 7'd0, 5'd0, 2'b11);
    check("add_aluop", 32'(bus.ALUOp), 2);
    check("add_regwrite", 32'(bus.RegWrite), 1);
    check("add_valid", 32'(bus.valid), 1);
    drive(7'b0110011, 3'b000, 7'b0000001, 5'd0, 2'b11);
    check("op_f7_exc", 32'(bus.exc_req), 1);

    drive(7'b1100011, 3'b001, 7'd0, 5'd0, 2'b11);
    check("bne_branch", 32'(bus.Branch), 32'h02);
    check("bne_aluop", 32'(bus.ALUOp), 1);
    drive(7'b1100011, 3'b111, 7'd0, 5'd0, 2'b11);
    check("bgeu_branch", 32'(bus.Branch), 32'h20);
    drive(7'b1100011, 3'b010, 7'd0, 5'd0, 2'b11);
    check("br_010_exc", 32'(bus.exc_req), 1);
    check("br_010_branch", 32'(bus.Branch), 0);

    drive(7'b0100011, 3'b010, 7'd0, 5'd0, 2'b11);
    check("sw_memwrite", 32'(bus.MemWrite), 1);
    check("sw_regwrite", 32'(bus.RegWrite), 0);
    drive(7'b0100011, 3'b011, 7'd0, 5'd0, 2'b11);
    check("sd_exc", 32'(bus.exc_req), 1);

    drive(7'b0101111, 3'b010, 7'd0, 5'b00010, 2'b11);
    check("lrw_memwrite", 32'(bus.MemWrite), 0);
    check("lrw_addrsel", 32'(bus.dmem_addr_sel), 1);
    check("lrw_memread", 32'(bus.MemRead), 1);
    drive(7'b0101111, 3'b010, 7'd0, 5'b00011, 2'b11);
    check("scw_memwrite", 32'(bus.MemWrite), 1);

    drive(7'b1101111, 3'b000, 7'd0, 5'd0, 2'b11);
    check("jal_jal", 32'(bus.jal), 1);
    check("jal_memtoreg", 32'(bus.MemtoReg), 2);
    drive(7'b1100111, 3'b000, 7'd0, 5'd0, 2'b11);
    check("jalr_jalr", 32'(bus.jalr), 1);
    check("jalr_alusrcb", 32'(bus.ALUSrcB), 1);
    drive(7'b0110111, 3'b000, 7'd0, 5'd0, 2'b11);
    check("lui_alusrca", 32'(bus.ALUSrcA), 2);
    drive(7'b0010111, 3'b000, 7'd0, 5'd0, 2'b11);
    check("auipc_alusrca", 32'(bus.ALUSrcA), 1);
    drive(7'b0010011, 3'b000, 7'd0, 5'd0, 2'b11);
    check("addi_aluop", 32'(bus.ALUOp), 3);
    drive(7'b0001111, 3'b000, 7'd0, 5'd0, 2'b11);
    check("fence_valid", 32'(bus.valid), 1);
    check("fence_regwrite", 32'(bus.RegWrite), 0);

    // Mid-stream reset discards the word that would have been captured.
    rst_n = 1'b0;
    drive(7'b0110011, 3'b000, 7'd0, 5'd0, 2'b11);
    check("midrst_regwrite", 32'(bus.RegWrite), 0);
    check("midrst_valid", 32'(bus.valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
